// File: rtl/rr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_pkg
// Description : Shared constants, state encoding and round-robin pick helper
//               for the rr_decoder_arbiter block.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_arb_pkg;

   localparam int NUM_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // First set request bit at or above ptr, wrapping 7->0. The index sum is
   // IDX_W bits wide, so the wrap falls out of the natural overflow.
   function automatic logic [IDX_W-1:0] rr_pick(
      input logic [NUM_REQ-1:0] req,
      input logic [IDX_W-1:0]   ptr
   );
      logic [IDX_W-1:0] idx;
      logic             found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ptr + IDX_W'(k);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/dec3to8.sv
`default_nettype none
// ============================================================================
// Module      : dec3to8
// Description : 3-to-8 one-hot decoder with enable; all zero when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module dec3to8
   import rr_arb_pkg::*;
(
   input  logic [IDX_W-1:0]   i_idx,
   input  logic               i_en,
   output logic [NUM_REQ-1:0] o_onehot
);

   // Set the single bit selected by the index when enabled.
   always_comb begin
      o_onehot = '0;
      if (i_en) begin
         o_onehot[i_idx] = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/rr_decoder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_decoder_arbiter
// Description : 8-way round-robin arbiter with a bounded hold time. A grant is
//               always followed by at least one idle cycle; exceeding the hold
//               limit force-releases the owner and pulses timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_decoder_arbiter
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 15
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               done,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid,
   output logic               timeout
);

   localparam int                HOLD_W     = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] C_HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] C_HOLD_ONE = HOLD_W'(1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    r_owner;
   logic [IDX_W-1:0]    w_owner_nxt;
   logic [IDX_W-1:0]    r_ptr;
   logic [IDX_W-1:0]    w_ptr_nxt;
   logic [HOLD_W-1:0]   r_hold;
   logic [HOLD_W-1:0]   w_hold_nxt;
   logic                r_timeout;
   logic                w_timeout_nxt;
   logic                w_limit;

   assign w_limit = (r_hold == C_HOLD_MAX);

   // Next-state logic: arbitrate in IDLE, watch for release in GRANT.
   always_comb begin
      w_state_nxt   = r_state;
      w_owner_nxt   = r_owner;
      w_ptr_nxt     = r_ptr;
      w_hold_nxt    = r_hold;
      w_timeout_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            if (|req) begin
               w_state_nxt = GRANT;
               w_owner_nxt = rr_pick(req, r_ptr);
               w_hold_nxt  = C_HOLD_ONE;
            end
         end
         GRANT: begin
            if (done || !req[r_owner] || w_limit) begin
               w_state_nxt   = IDLE;
               w_ptr_nxt     = r_owner + IDX_W'(1);
               w_hold_nxt    = '0;
               // Only a release caused purely by the hold limit is a timeout.
               w_timeout_nxt = w_limit && !done && req[r_owner];
            end else begin
               w_hold_nxt = r_hold + C_HOLD_ONE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register; reset overrides every other input.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_owner   <= '0;
         r_ptr     <= '0;
         r_hold    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_owner   <= w_owner_nxt;
         r_ptr     <= w_ptr_nxt;
         r_hold    <= w_hold_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   // Outputs are decoded from registered state only.
   assign grant_valid = (r_state == GRANT);
   assign grant_idx   = grant_valid ? r_owner : '0;
   assign timeout     = r_timeout;

   dec3to8 u_dec (
      .i_idx    (grant_idx),
      .i_en     (grant_valid),
      .o_onehot (grant)
   );

endmodule
`default_nettype wire

// File: doc/rr_decoder_arbiter.md
RR_DECODER_ARBITER -- requirements
Module: rr_decoder_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 15, giving the maximum number of consecutive cycles one requester may hold a grant (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 8 bits: request from requester i on bit i.
REQ-005 The block SHALL have port done, input, 1 bit: current owner releases its grant.
REQ-006 The block SHALL have port grant, output, 8 bits: one-hot grant, or all zero.
REQ-007 The block SHALL have port grant_idx, output, 3 bits: binary index of the current owner, or 0 when idle.
REQ-008 The block SHALL have port grant_valid, output, 1 bit: high while any grant bit is high.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is force-released.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE (no grant) and GRANT (one owner).
REQ-011 In IDLE with req nonzero at a rising edge, the block SHALL enter GRANT on that edge, with owner = first set req bit scanning upward from ptr and wrapping 7->0.
REQ-012 In IDLE with req == 0, the block SHALL stay in IDLE with ptr unchanged.
REQ-013 grant SHALL equal the 3-to-8 decode of grant_idx, gated by grant_valid; outputs SHALL be registered state only, with no combinational path from req or done.
REQ-014 In GRANT, the block SHALL return to IDLE on the first edge where done = 1, or req[owner] = 0, or the hold count equals MAX_HOLD.
REQ-015 On every GRANT->IDLE transition, ptr SHALL become (owner + 1) mod 8, wrapping 7->0.
REQ-016 The hold count SHALL load 1 on entering GRANT, increment each GRANT cycle, and be $clog2(MAX_HOLD+1) bits wide, never wrapping.
REQ-017 timeout SHALL pulse high for exactly the one cycle after release caused only by the hold limit; if done or a dropped request coincides with the limit, timeout SHALL stay low.
REQ-018 There SHALL be at least one IDLE cycle between consecutive grants, so grant is never one-hot for two different owners on adjacent cycles.
REQ-019 Requests changing on non-owner bits during GRANT SHALL have no effect until the next IDLE arbitration.
REQ-020 A done input asserted in IDLE SHALL be ignored.

Reset
REQ-021 When reset = 1 at a rising edge, the block SHALL set state = IDLE, ptr = 0, hold count = 0, grant = 8'h00, grant_idx = 0, grant_valid = 0 and timeout = 0.
REQ-022 Reset asserted mid-grant SHALL drop the grant on that edge without asserting timeout; reset SHALL take priority over all other inputs.

Structure
REQ-023 The state encoding (IDLE, GRANT) and constants NUM_REQ = 8 and IDX_W = 3 SHALL live in a shared package, rr_arb_pkg.
REQ-024 The one-hot decode SHALL be a sub-module, dec3to8 (3-bit index plus enable in, 8-bit one-hot out), instantiated once.

Verification
REQ-025 The bench SHALL cover reset-to-first-grant:
- Stimulus: reset for 2 cycles, then req = 8'h05 held, done pulsed on the 3rd grant cycle.
- Required response: grant = 8'h01, grant_idx = 0 one edge after reset is released; release, one idle cycle, then grant = 8'h04.
REQ-026 The bench SHALL cover pointer wrap:
- Stimulus: ptr = 7 after owner 6 released, req = 8'h81.
- Required response: grant = 8'h80; after release, grant = 8'h01.
REQ-027 The bench SHALL cover timeout:
- Stimulus: MAX_HOLD = 3, req = 8'h02 held, done = 0.
- Required response: grant = 8'h02 for exactly 3 cycles, then timeout = 1 for 1 cycle, grant = 0; re-granted to 1 after one idle cycle.
REQ-028 The bench SHALL cover a simultaneous limit and done:
- Stimulus: done = 1 on the same edge the hold limit is reached.
- Required response: grant released, timeout stays 0.
REQ-029 The bench SHALL cover reset mid-operation:
- Stimulus: reset = 1 during grant to owner 5.
- Required response: next cycle all outputs are 0; the next request set 8'h20 is granted with ptr starting at 0.
REQ-030 The bench SHALL cover fairness:
- Stimulus: req = 8'hFF held, done pulsed every grant cycle.
- Required response: owners appear in the order 0,1,...,7,0, and grant is one-hot or zero in every cycle.
